// File: rtl/icache_pkg.sv
// Shared types and default geometry for the N-way instruction-cache controller.
package icache_pkg;

    localparam int DEF_WAYS    = 4;
    localparam int DEF_S_INDEX = 3;
    localparam int DEF_BEATS   = 4;

    typedef enum logic [1:0] {
        ST_CHECK = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_nway_control_if.sv
// CPU-side, datapath-side and pmem-side control signals of the icache controller.
interface icache_nway_control_if
    import icache_pkg::*;
#(
    parameter int WAYS    = DEF_WAYS,
    parameter int S_INDEX = DEF_S_INDEX,
    parameter int BEATS   = DEF_BEATS
) ();

    localparam int BW = clog2_min1(BEATS);

    logic               mem_read;
    logic [S_INDEX-1:0] mem_index;
    logic [WAYS-1:0]    hit_vec;
    logic [WAYS-1:0]    valid_vec;
    logic               flush;
    logic               pmem_resp;

    logic               mem_resp;
    logic               pmem_read;
    logic [WAYS-1:0]    load_tag;
    logic [WAYS-1:0]    load_valid;
    logic [WAYS-1:0]    load_beat;
    logic [BW-1:0]      beat_idx;
    logic               clear_valid;
    logic [S_INDEX-1:0] flush_idx;
    logic               busy;

    modport slave (
        input  mem_read, mem_index, hit_vec, valid_vec, flush, pmem_resp,
        output mem_resp, pmem_read, load_tag, load_valid, load_beat,
        output beat_idx, clear_valid, flush_idx, busy
    );

    modport master (
        output mem_read, mem_index, hit_vec, valid_vec, flush, pmem_resp,
        input  mem_resp, pmem_read, load_tag, load_valid, load_beat,
        input  beat_idx, clear_valid, flush_idx, busy
    );

endinterface

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: victim lookup and access update. The root splits on
// way bit 0, the next level on bit 1, and so on; bit value = victim side.
module plru_tree #(
    parameter  int WAYS = 4,
    localparam int WW   = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] bits_i,
    input  logic [WW-1:0]   way_i,
    output logic [WW-1:0]   victim_o,
    output logic [WAYS-2:0] bits_o
);

    always_comb begin
        int nv;
        int na;
        nv       = 0;
        na       = 0;
        victim_o = '0;
        bits_o   = bits_i;
        for (int l = 0; l < WW; l++) begin
            victim_o[l] = bits_i[nv];
            nv          = 2 * nv + 1 + int'(bits_i[nv]);
        end
        // Point every node on the accessed path away from the accessed way.
        for (int l = 0; l < WW; l++) begin
            bits_o[na] = ~way_i[l];
            na         = 2 * na + 1 + int'(way_i[l]);
        end
    end

endmodule

// File: rtl/icache_nway_control.sv
// Instruction-cache control FSM: hit check, burst line fill into a PLRU/invalid
// victim way, and a one-set-per-cycle flush sweep.
module icache_nway_control
    import icache_pkg::*;
#(
    parameter int WAYS    = DEF_WAYS,
    parameter int S_INDEX = DEF_S_INDEX,
    parameter int BEATS   = DEF_BEATS
) (
    input logic                  clk,
    input logic                  rst,
    icache_nway_control_if.slave bus
);

    localparam int SETS = 2 ** S_INDEX;
    localparam int WW   = $clog2(WAYS);
    localparam int BW   = clog2_min1(BEATS);

    localparam logic [BW-1:0]      LAST_BEAT = BW'(BEATS - 1);
    localparam logic [S_INDEX-1:0] LAST_SET  = S_INDEX'(SETS - 1);
    localparam logic [WAYS-1:0]    ONE_WAY   = WAYS'(1);

    state_e             state_q, state_d;
    logic [BW-1:0]      cnt_q, cnt_d;
    logic [S_INDEX-1:0] fidx_q, fidx_d;
    logic               pend_q, pend_d;
    logic [S_INDEX-1:0] fill_idx_q, fill_idx_d;
    logic [WW-1:0]      victim_q, victim_d;
    logic [WAYS-2:0]    plru_q [SETS];
    logic [WAYS-2:0]    plru_d [SETS];

    logic               hit_any;
    logic [WW-1:0]      hit_way;
    logic               inv_any;
    logic [WW-1:0]      inv_way;
    logic [WAYS-2:0]    tree_in;
    logic [WW-1:0]      tree_way;
    logic [WW-1:0]      tree_victim;
    logic [WAYS-2:0]    tree_upd;
    logic [WW-1:0]      victim;

    logic               mem_resp;
    logic               pmem_read;
    logic               beat_en;
    logic               line_done;
    logic               clear_valid;
    logic               busy;
    logic [BW-1:0]      beat_idx;
    logic [S_INDEX-1:0] flush_idx;

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (bus.hit_vec[w]) hit_way = WW'(w);
            if (!bus.valid_vec[w]) inv_way = WW'(w);
        end
    end

    assign hit_any  = |bus.hit_vec;
    assign inv_any  = ~&bus.valid_vec;
    // One tree serves both the CHECK hit update and the end-of-fill update.
    assign tree_in  = (state_q == ST_FILL) ? plru_q[fill_idx_q] : plru_q[bus.mem_index];
    assign tree_way = (state_q == ST_FILL) ? victim_q : hit_way;
    assign victim   = inv_any ? inv_way : tree_victim;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_i   (tree_in),
        .way_i    (tree_way),
        .victim_o (tree_victim),
        .bits_o   (tree_upd)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fidx_d      = fidx_q;
        pend_d      = pend_q;
        fill_idx_d  = fill_idx_q;
        victim_d    = victim_q;
        plru_d      = plru_q;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        beat_en     = 1'b0;
        line_done   = 1'b0;
        clear_valid = 1'b0;
        busy        = 1'b0;
        beat_idx    = '0;
        flush_idx   = '0;
        unique case (state_q)
            ST_CHECK: begin
                if (pend_q || bus.flush) begin
                    pend_d  = 1'b0;
                    state_d = ST_FLUSH;
                end else if (bus.mem_read) begin
                    if (hit_any) begin
                        mem_resp               = 1'b1;
                        plru_d[bus.mem_index]  = tree_upd;
                    end else begin
                        fill_idx_d = bus.mem_index;
                        victim_d   = victim;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                busy      = 1'b1;
                pmem_read = 1'b1;
                if (bus.flush) pend_d = 1'b1;
                if (bus.pmem_resp) begin
                    beat_en  = 1'b1;
                    beat_idx = cnt_q;
                    if (cnt_q == LAST_BEAT) begin
                        line_done          = 1'b1;
                        plru_d[fill_idx_q] = tree_upd;
                        cnt_d              = '0;
                        state_d            = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                busy           = 1'b1;
                clear_valid    = 1'b1;
                flush_idx      = fidx_q;
                plru_d[fidx_q] = '0;
                if (fidx_q == LAST_SET) begin
                    fidx_d  = '0;
                    state_d = ST_CHECK;
                end else begin
                    fidx_d = fidx_q + 1'b1;
                end
            end
            default: state_d = ST_CHECK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CHECK;
            cnt_q      <= '0;
            fidx_q     <= '0;
            pend_q     <= 1'b0;
            fill_idx_q <= '0;
            victim_q   <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fidx_q     <= fidx_d;
            pend_q     <= pend_d;
            fill_idx_q <= fill_idx_d;
            victim_q   <= victim_d;
            plru_q     <= plru_d;
        end
    end

    assign bus.mem_resp    = mem_resp & ~rst;
    assign bus.pmem_read   = pmem_read & ~rst;
    assign bus.load_beat   = (beat_en & ~rst) ? (ONE_WAY << victim_q) : '0;
    assign bus.load_tag    = (line_done & ~rst) ? (ONE_WAY << victim_q) : '0;
    assign bus.load_valid  = (line_done & ~rst) ? (ONE_WAY << victim_q) : '0;
    assign bus.beat_idx    = rst ? '0 : beat_idx;
    assign bus.clear_valid = clear_valid & ~rst;
    assign bus.flush_idx   = rst ? '0 : flush_idx;
    assign bus.busy        = busy & ~rst;

endmodule

// File: tb/tb_icache_nway_control.sv
// Directed bench for icache_nway_control: fills, PLRU victims, gapped beats,
// flush sweeps and mid-fill reset, all against hand-computed vectors.
module tb_icache_nway_control;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    icache_nway_control_if #(.WAYS(4), .S_INDEX(3), .BEATS(4)) bus ();

    icache_nway_control #(.WAYS(4), .S_INDEX(3), .BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        bus.mem_read  = 1'b0;
        bus.mem_index = '0;
        bus.hit_vec   = '0;
        bus.valid_vec = '0;
        bus.flush     = 1'b0;
        bus.pmem_resp = 1'b0;
    endtask

    task automatic request(input logic [2:0] idx, input logic [3:0] valid, input logic [3:0] hit);
        bus.mem_read  = 1'b1;
        bus.mem_index = idx;
        bus.valid_vec = valid;
        bus.hit_vec   = hit;
    endtask

    // Runs the FILL state for ncyc cycles; pat bit c = pmem_resp on cycle c.
    task automatic fill(input string tag, input logic [15:0] pat, input int ncyc,
                        input logic [3:0] way, input int flush_cyc);
        int  b;
        logic last;
        b = 0;
        for (int c = 0; c < ncyc; c++) begin
            bus.pmem_resp = pat[c];
            bus.flush     = (c == flush_cyc);
            last          = pat[c] && (b == 3);
            #1;
            check({tag, ".pmem_read"}, bus.pmem_read, 1);
            check({tag, ".busy"}, bus.busy, 1);
            check({tag, ".mem_resp"}, bus.mem_resp, 0);
            check({tag, ".load_beat"}, bus.load_beat, pat[c] ? way : 4'b0);
            check({tag, ".beat_idx"}, bus.beat_idx, pat[c] ? b : 0);
            check({tag, ".load_tag"}, bus.load_tag, last ? way : 4'b0);
            check({tag, ".load_valid"}, bus.load_valid, last ? way : 4'b0);
            if (pat[c]) b++;
            tick();
        end
        bus.pmem_resp = 1'b0;
        bus.flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst.mem_resp", bus.mem_resp, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.pmem_read", bus.pmem_read, 0);
        check("rst.clear_valid", bus.clear_valid, 0);
        tick();

        // Cold miss on set 2 fills way 0, then hits.
        request(3'd2, 4'b0000, 4'b0000);
        #1;
        check("m37.mem_resp", bus.mem_resp, 0);
        check("m37.busy", bus.busy, 0);
        tick();
        fill("f37", 16'h000F, 4, 4'b0001, -1);
        bus.hit_vec   = 4'b0001;
        bus.valid_vec = 4'b0001;
        #1;
        check("h37.mem_resp", bus.mem_resp, 1);
        check("h37.busy", bus.busy, 0);
        tick();
        idle();

        // Set 5 full: hits 0,1,2 leave way 3 as victim; then hit 3 -> way 0.
        request(3'd5, 4'b1111, 4'b0000);
        for (int w = 0; w < 3; w++) begin
            bus.hit_vec = 4'(1 << w);
            #1;
            check("h38.mem_resp", bus.mem_resp, 1);
            tick();
        end
        bus.hit_vec = 4'b0000;
        #1;
        check("m38a.mem_resp", bus.mem_resp, 0);
        tick();
        fill("f38a", 16'h000F, 4, 4'b1000, -1);
        bus.hit_vec = 4'b1000;
        #1;
        check("h38b.mem_resp", bus.mem_resp, 1);
        tick();
        bus.hit_vec = 4'b0000;
        tick();
        fill("f38b", 16'h000F, 4, 4'b0001, -1);
        bus.hit_vec = 4'b0001;
        #1;
        check("h38c.mem_resp", bus.mem_resp, 1);
        tick();
        idle();

        // Gapped beats on FILL cycles 1,4,5,9.
        request(3'd1, 4'b0000, 4'b0000);
        tick();
        fill("f39", 16'h0232, 10, 4'b0001, -1);
        bus.hit_vec   = 4'b0001;
        bus.valid_vec = 4'b0001;
        #1;
        check("h39.mem_resp", bus.mem_resp, 1);
        tick();
        idle();

        // Flush during beat 2: fill completes, then an 8-set sweep.
        request(3'd3, 4'b0000, 4'b0000);
        tick();
        fill("f40", 16'h000F, 4, 4'b0001, 2);
        #1;
        check("p40.mem_resp", bus.mem_resp, 0);
        check("p40.clear_valid", bus.clear_valid, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            bus.mem_index = 3'(k);
            bus.flush     = (k == 4);
            #1;
            check("s40.clear_valid", bus.clear_valid, 1);
            check("s40.flush_idx", bus.flush_idx, k);
            check("s40.busy", bus.busy, 1);
            check("s40.pmem_read", bus.pmem_read, 0);
            tick();
        end
        bus.flush = 1'b0;
        request(3'd5, 4'b1111, 4'b0001);
        #1;
        check("e40.clear_valid", bus.clear_valid, 0);
        check("e40.hit5", bus.mem_resp, 1);
        tick();
        request(3'd3, 4'b0000, 4'b0000);
        #1;
        check("r40.mem_resp", bus.mem_resp, 0);
        check("r40.busy", bus.busy, 0);
        tick();
        #1;
        check("r40.refill", bus.pmem_read, 1);

        // Reset on beat 1 of that fill.
        bus.pmem_resp = 1'b1;
        #1;
        check("f41.beat0", bus.beat_idx, 0);
        tick();
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.pmem_resp = 1'b0;
        #1;
        check("r41.pmem_read", bus.pmem_read, 0);
        check("r41.busy", bus.busy, 0);
        check("r41.mem_resp", bus.mem_resp, 0);
        check("r41.load_beat", bus.load_beat, 0);
        // Set 5 PLRU was trained to way 1; reset must bring the victim back to way 0.
        request(3'd5, 4'b1111, 4'b0000);
        tick();
        fill("f41", 16'h000F, 4, 4'b0001, -1);
        bus.hit_vec = 4'b0001;
        #1;
        check("h41.mem_resp", bus.mem_resp, 1);
        tick();
        idle();

        // Multi-hit 0110 counts as way 1, so the next victim is way 0.
        request(3'd6, 4'b1111, 4'b0110);
        #1;
        check("h42.mem_resp", bus.mem_resp, 1);
        tick();
        bus.hit_vec = 4'b0000;
        tick();
        fill("f42", 16'h000F, 4, 4'b0001, -1);

        // Flush beats a pending hit in CHECK.
        request(3'd6, 4'b1111, 4'b0001);
        bus.flush = 1'b1;
        #1;
        check("fc.mem_resp", bus.mem_resp, 0);
        check("fc.busy", bus.busy, 0);
        tick();
        bus.flush = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fc.flush_idx", bus.flush_idx, k);
            tick();
        end
        #1;
        check("fc.after", bus.mem_resp, 1);
        check("fc.idle", bus.busy, 0);
        tick();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
